tl_a_fifo_unpack: RTL and testbench
===================================

Name: tl_a_fifo_unpack

Overview:
- Read-side stage directly downstream of the asynchronous FIFO on the TileLink A channel; runs entirely in the FIFO read clock domain.
- Pops packed A-channel words through the FIFO's pop interface (combinational head data, empty flag, pop enable).
- Unpacks each word into TileLink A fields and adds burst framing (first/last beat).
- Drops malformed requests and presents a registered valid/ready A channel through a 2-entry output buffer.

Parameters:
- ADDR_W, 32, A-channel address width.
- DATA_W, 32, beat data width; power of 2, ≥8; LG_BYTES = log2(DATA_W/8).
- SRC_W, 4, source ID width.
- SIZE_W, 4, size field width (log2 bytes).
- MAX_SIZE, 6, largest legal a_size; larger sizes are errors.
- FIFO_W (localparam) = 3+3+SIZE_W+SRC_W+ADDR_W+DATA_W/8+DATA_W; 82 at defaults.

Ports:
- rd_clk  in  1  block clock (FIFO read clock).
- rd_reset_n  in  1  asynchronous active-low reset.
- fifo_rd_data  in  FIFO_W  FIFO head word, MSB→LSB: opcode[3], param[3], size, source, address, mask, data.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pop FIFO head this cycle.
- a_valid  out  1  A beat valid.
- a_ready  in  1  downstream accept.
- a_opcode  out  3  A opcode.
- a_param  out  3  A param.
- a_size  out  SIZE_W  A size.
- a_source  out  SRC_W  A source ID.
- a_address  out  ADDR_W  A address.
- a_mask  out  DATA_W/8  byte mask.
- a_data  out  DATA_W  beat data.
- a_first  out  1  first beat of message.
- a_last  out  1  last beat of message.
- busy  out  1  multi-beat burst partially unpacked (beats_left≠0).
- err_pulse  out  1  one-cycle pulse when a word is dropped.
- err_cnt  out  8  saturating count of dropped words.

Behaviour:
- Clock and reset: one clock, rd_clk; reset is asynchronous, active-low on rd_reset_n.
- Reset values: buffer empty, a_valid=0, all A fields=0, a_first=a_last=0, busy=0, beats_left=0, err_pulse=0, err_cnt=0. fifo_rd_en is combinational and is 0 while fifo_rd_empty=1.
- Reset mid-burst: the partial message is discarded; no resumption.
- Output buffer:
  - 2 entries; a_* outputs are driven from registers of the head entry.
  - An entry retires on a_valid&&a_ready.
  - While a_valid=1 and a_ready=0, all outputs are held stable.
- Pop rule: fifo_rd_en = !fifo_rd_empty && (count<2 || (count==2 && a_valid && a_ready)).
- Latency and throughput:
  - A word popped at edge N appears on the outputs after edge N (1-cycle latency with an empty buffer).
  - With a_ready held at 1, throughput is 1 beat/cycle.
  - A push and a retire in the same cycle keep the count unchanged.
- Beat tracking: evaluated only on the popped word.
- First-beat case (beats_left==0):
  - Legal = opcode∈{0..5} && size≤MAX_SIZE.
  - Illegal → word dropped (no push); err_pulse=1 next cycle; err_cnt += 1, saturating at 255.
  - Legal → beats = 1 for opcodes 4 (Get) and 5 (Intent), or when size≤LG_BYTES; else beats = 1<<(size−LG_BYTES).
  - Latch opcode, param, size, source, address as the burst header.
  - Push entry with first=1, last=(beats==1); beats_left ← beats−1.
- Continuation case (beats_left≠0):
  - No legality check on opcode/param/size/source/address; those fields of the word are ignored.
  - Entry takes header fields from the latched header and mask/data from the word.
  - first=0; last=(beats_left==1); beats_left decrements.
- busy = (beats_left≠0).
- beats_left width is MAX_SIZE−LG_BYTES+1 bits; no wrap at MAX_SIZE.
- Dropped words still pop the FIFO (they consume a slot decision identically).
- err_pulse is a registered single-cycle pulse; back-to-back drops give consecutive pulses.

Test Plan:
- Single Get: push {op=4, size=6, src=3, addr=0x1000} → one beat, a_first=a_last=1, a_size=6, a_address=0x1000, 1 cycle after pop.
- PutFull burst: op=0, size=4, addr=0x2000, 4 words with data 0xA0..0xA3 (continuation headers garbage) → 4 beats, all addr=0x2000, src as first word, first on beat 0, last on beat 3, busy=1 between.
- Backpressure: fill FIFO with 5 Gets, a_ready=0 for 10 cycles → fifo_rd_en stops after 2 pops, outputs stable; a_ready=1 → 5 beats in order at 1/cycle.
- Illegal opcode 7 then illegal size 7 then Get → 2 err_pulses, err_cnt=2, only the Get emitted; 300 illegal words → err_cnt=255.
- Reset mid-burst: assert rd_reset_n=0 after beat 1 of a 4-beat PutFull → all outputs 0, busy=0; next Get emitted with a_first=1.
- Simultaneous push/retire with count=2 and a_ready=1 → pop occurs, count stays 2, no beat lost or duplicated.

Source files
------------

// File: rtl/tl_a_fifo_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tl_a_fifo_unpack
// Purpose  : Read-side unpacker for the TileLink A-channel async FIFO.
//            Pops packed words, adds burst first/last framing, drops
//            malformed requests and presents a 2-entry buffered A channel.
// Revision : 1.0 - initial release
// ============================================================================
module tl_a_fifo_unpack #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SRC_W    = 4,
    parameter int SIZE_W   = 4,
    parameter int MAX_SIZE = 6
) (
    input  logic                                                  rd_clk,
    input  logic                                                  rd_reset_n,
    input  logic [3+3+SIZE_W+SRC_W+ADDR_W+DATA_W/8+DATA_W-1:0]    fifo_rd_data,
    input  logic                                                  fifo_rd_empty,
    output logic                                                  fifo_rd_en,
    output logic                                                  a_valid,
    input  logic                                                  a_ready,
    output logic [2:0]                                            a_opcode,
    output logic [2:0]                                            a_param,
    output logic [SIZE_W-1:0]                                     a_size,
    output logic [SRC_W-1:0]                                      a_source,
    output logic [ADDR_W-1:0]                                     a_address,
    output logic [DATA_W/8-1:0]                                   a_mask,
    output logic [DATA_W-1:0]                                     a_data,
    output logic                                                  a_first,
    output logic                                                  a_last,
    output logic                                                  busy,
    output logic                                                  err_pulse,
    output logic [7:0]                                            err_cnt
);

    localparam int MASK_W   = DATA_W / 8;
    localparam int LG_BYTES = $clog2(MASK_W);
    localparam int FIFO_W   = 3 + 3 + SIZE_W + SRC_W + ADDR_W + MASK_W + DATA_W;
    localparam int HDR_W    = 3 + 3 + SIZE_W + SRC_W + ADDR_W;
    localparam int ENT_W    = HDR_W + MASK_W + DATA_W + 2;
    localparam int BL_W     = MAX_SIZE - LG_BYTES + 1;

    localparam logic [SIZE_W-1:0] c_lg_bytes = SIZE_W'(LG_BYTES);
    localparam logic [SIZE_W-1:0] c_max_size = SIZE_W'(MAX_SIZE);
    localparam logic [BL_W-1:0]   c_one      = BL_W'(1);

    // Buffer state: r_ent0 is always the head entry and drives the A channel
    logic [1:0]        r_count;
    logic              r_valid;
    logic [ENT_W-1:0]  r_ent0;
    logic [ENT_W-1:0]  r_ent1;
    logic [HDR_W-1:0]  r_hdr;
    logic [BL_W-1:0]   r_beats_left;
    logic              r_err_pulse;
    logic [7:0]        r_err_cnt;

    // Decoded view of the FIFO head word
    logic [2:0]        w_word_op;
    logic [SIZE_W-1:0] w_word_size;
    logic [HDR_W-1:0]  w_word_hdr;
    logic [MASK_W-1:0] w_word_mask;
    logic [DATA_W-1:0] w_word_data;

    logic              w_retire;
    logic              w_pop;
    logic              w_first_case;
    logic              w_legal;
    logic              w_single;
    logic [SIZE_W-1:0] w_shift;
    logic [BL_W-1:0]   w_beats_m1;
    logic              w_push;
    logic              w_drop;
    logic              w_last;
    logic [ENT_W-1:0]  w_new_ent;
    logic              w_slot0;
    logic [1:0]        w_count_nxt;

    assign w_word_hdr  = fifo_rd_data[FIFO_W-1 -: HDR_W];
    assign w_word_op   = fifo_rd_data[FIFO_W-1 -: 3];
    assign w_word_size = fifo_rd_data[FIFO_W-7 -: SIZE_W];
    assign w_word_mask = fifo_rd_data[DATA_W +: MASK_W];
    assign w_word_data = fifo_rd_data[DATA_W-1:0];

    assign w_retire = r_valid && a_ready;
    assign w_pop    = !fifo_rd_empty &&
                      ((r_count < 2'd2) || ((r_count == 2'd2) && w_retire));

    // Legality is only judged on the first word of a message
    assign w_first_case = (r_beats_left == '0);
    assign w_legal      = (w_word_op <= 3'd5) && (w_word_size <= c_max_size);
    assign w_push       = w_pop && (!w_first_case || w_legal);
    assign w_drop       = w_pop && w_first_case && !w_legal;

    // Get/Intent and sub-beat sizes are single-beat; otherwise 2^(size-LG_BYTES)
    assign w_single   = (w_word_op == 3'd4) || (w_word_op == 3'd5) ||
                        (w_word_size <= c_lg_bytes);
    assign w_shift    = w_word_size - c_lg_bytes;
    assign w_beats_m1 = w_single ? '0 : ((c_one << w_shift) - c_one);

    assign w_last    = w_first_case ? w_single : (r_beats_left == c_one);
    assign w_new_ent = {(w_first_case ? w_word_hdr : r_hdr),
                        w_word_mask, w_word_data, w_first_case, w_last};

    // New entry lands behind whatever survives this cycle's retire
    assign w_slot0 = (r_count == 2'd0) || ((r_count == 2'd1) && w_retire);

    // Occupancy after this cycle's push/retire
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_retire) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_retire) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Output buffer: shift on retire, write the incoming entry into its slot
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            r_count <= 2'd0;
            r_valid <= 1'b0;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
            if (w_retire && (r_count == 2'd2)) begin
                r_ent0 <= r_ent1;
            end
            if (w_push) begin
                if (w_slot0) begin
                    r_ent0 <= w_new_ent;
                end else begin
                    r_ent1 <= w_new_ent;
                end
            end
        end
    end

    // Burst tracking: latch the header on the first beat, count down the rest
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            r_hdr        <= '0;
            r_beats_left <= '0;
        end else if (w_push) begin
            if (w_first_case) begin
                r_hdr        <= w_word_hdr;
                r_beats_left <= w_beats_m1;
            end else begin
                r_beats_left <= r_beats_left - c_one;
            end
        end
    end

    // Drop reporting: one pulse per dropped word plus a saturating tally
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            r_err_pulse <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_err_pulse <= w_drop;
            if (w_drop && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign fifo_rd_en = w_pop;
    assign a_valid    = r_valid;
    assign {a_opcode, a_param, a_size, a_source, a_address,
            a_mask, a_data, a_first, a_last} = r_ent0;
    assign busy       = (r_beats_left != '0);
    assign err_pulse  = r_err_pulse;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tl_a_fifo_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_a_fifo_unpack
// Purpose  : Self-checking bench for tl_a_fifo_unpack. A queue stands in for
//            the async FIFO; expected beats are produced per message when the
//            stimulus is generated.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_a_fifo_unpack;

    localparam int FIFO_W = 82;
    localparam int BEAT_W = 84;

    logic              rd_clk;
    logic              rd_reset_n;
    logic [FIFO_W-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic              fifo_rd_en;
    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [3:0]        a_size;
    logic [3:0]        a_source;
    logic [31:0]       a_address;
    logic [3:0]        a_mask;
    logic [31:0]       a_data;
    logic              a_first;
    logic              a_last;
    logic              busy;
    logic              err_pulse;
    logic [7:0]        err_cnt;

    tl_a_fifo_unpack u_dut (
        .rd_clk        (rd_clk),
        .rd_reset_n    (rd_reset_n),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_en    (fifo_rd_en),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_opcode      (a_opcode),
        .a_param       (a_param),
        .a_size        (a_size),
        .a_source      (a_source),
        .a_address     (a_address),
        .a_mask        (a_mask),
        .a_data        (a_data),
        .a_first       (a_first),
        .a_last        (a_last),
        .busy          (busy),
        .err_pulse     (err_pulse),
        .err_cnt       (err_cnt)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [FIFO_W-1:0] w;
        bit                legal;
        bit                busy_after;
    } word_t;

    word_t             fq[$];
    logic [BEAT_W-1:0] eq[$];

    int n_checks;
    int n_err;
    int ready_prob;
    int n_pops;

    // Reference state: buffer occupancy, burst-in-progress, drop reporting
    int          m_occ;
    bit          m_busy;
    bit          m_pulse;
    int          m_err;
    bit          snap_v;
    logic [BEAT_W-1:0] snap;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BEAT_W-1:0] dut_beat();
        return {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_first, a_last};
    endfunction

    // Message-level generator: emits FIFO words and the beats they must become
    task automatic gen_msg(input logic [2:0] op, input logic [3:0] size, input logic [3:0] src,
                           input logic [31:0] addr, input int data_base);
        logic [2:0]  prm;
        logic [3:0]  mk;
        logic [31:0] dt;
        word_t       wd;
        int          nb;
        prm = 3'($urandom);
        if (op > 3'd5 || size > 4'd6) begin
            wd.w = {op, prm, size, src, addr, 4'($urandom), 32'($urandom)};
            wd.legal = 1'b0;
            wd.busy_after = 1'b0;
            fq.push_back(wd);
            return;
        end
        nb = (op >= 3'd4 || size <= 4'd2) ? 1 : (1 << (int'(size) - 2));
        for (int i = 0; i < nb; i++) begin
            mk = 4'($urandom);
            dt = (data_base >= 0) ? 32'(data_base + i) : 32'($urandom);
            if (i == 0)
                wd.w = {op, prm, size, src, addr, mk, dt};
            else
                wd.w = {3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 32'($urandom), mk, dt};
            wd.legal = 1'b1;
            wd.busy_after = (i != nb - 1);
            fq.push_back(wd);
            eq.push_back({op, prm, size, src, addr, mk, dt, (i == 0), (i == nb - 1)});
        end
    endtask

    // One clock: drive at the falling edge, check, then account for the rising edge
    task automatic tick();
        bit exp_en;
        bit pop;
        bit ret;
        if (fq.size() != 0) begin
            fifo_rd_data  = fq[0].w;
            fifo_rd_empty = 1'b0;
        end else begin
            fifo_rd_data  = '0;
            fifo_rd_empty = 1'b1;
        end
        a_ready = ($urandom_range(99) < ready_prob);
        #1;
        exp_en = (fq.size() != 0) && ((m_occ < 2) || (m_occ == 2 && a_ready));
        chk("a_valid", a_valid, (m_occ != 0));
        chk("fifo_rd_en", fifo_rd_en, exp_en);
        chk("busy", busy, m_busy);
        chk("err_pulse", err_pulse, m_pulse);
        chk("err_cnt", err_cnt, m_err);
        if (snap_v && a_valid) chk("stall_stable", dut_beat(), snap);
        ret = a_valid && a_ready;
        if (ret) begin
            if (eq.size() == 0) chk("beat_unexpected", dut_beat(), '0);
            else chk("beat", dut_beat(), eq.pop_front());
        end
        snap_v = a_valid && !a_ready;
        snap   = dut_beat();
        pop = fifo_rd_en && (fq.size() != 0);
        m_pulse = 1'b0;
        if (pop) begin
            n_pops++;
            if (!fq[0].legal) begin
                m_pulse = 1'b1;
                if (m_err < 255) m_err++;
            end else begin
                m_occ++;
            end
            m_busy = fq[0].busy_after;
            void'(fq.pop_front());
        end
        if (ret && m_occ > 0) m_occ--;
        @(negedge rd_clk);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((fq.size() != 0 || eq.size() != 0) && c < budget) begin
            tick();
            c++;
        end
        chk("drain_left", fq.size() + eq.size(), 0);
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once
    task automatic do_reset();
        rd_reset_n    = 1'b0;
        fifo_rd_empty = 1'b1;
        fifo_rd_data  = '0;
        a_ready       = 1'b0;
        fq.delete();
        eq.delete();
        #1;
        chk("rst_outputs", {a_valid, busy, err_pulse, err_cnt, dut_beat()}, 128'd0);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        m_occ = 0; m_busy = 0; m_pulse = 0; m_err = 0; snap_v = 0;
        @(negedge rd_clk);
        rd_reset_n = 1'b1;
    endtask

    initial begin
        int pops_before;
        n_checks = 0; n_err = 0; n_pops = 0;
        rd_reset_n = 1'b0;
        fifo_rd_empty = 1'b1;
        fifo_rd_data = '0;
        a_ready = 1'b0;
        @(negedge rd_clk);
        @(negedge rd_clk);
        do_reset();

        // Single Get
        ready_prob = 100;
        gen_msg(3'd4, 4'd6, 4'd3, 32'h1000, -1);
        drain(50);

        // PutFull burst, 4 beats with data A0..A3
        gen_msg(3'd0, 4'd4, 4'd5, 32'h2000, 'hA0);
        drain(50);

        // Backpressure: only two words may be taken while stalled
        for (int i = 0; i < 5; i++) gen_msg(3'd4, 4'd2, 4'(i), 32'h3000 + 32'(i * 4), -1);
        ready_prob = 0;
        pops_before = n_pops;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_pops", n_pops - pops_before, 2);
        ready_prob = 100;
        drain(50);

        // Illegal opcode, illegal size, then a Get
        gen_msg(3'd7, 4'd2, 4'd1, 32'h10, -1);
        gen_msg(3'd1, 4'd7, 4'd1, 32'h20, -1);
        gen_msg(3'd4, 4'd0, 4'd2, 32'h30, -1);
        drain(50);
        chk("err_cnt_two", err_cnt, 8'd2);

        // Saturation of the drop counter
        for (int i = 0; i < 300; i++) gen_msg(3'd6, 4'($urandom), 4'($urandom), 32'($urandom), -1);
        drain(400);
        tick();
        chk("err_cnt_sat", err_cnt, 8'd255);

        // Reset after beat 1 of a 4-beat PutFull
        do_reset();
        ready_prob = 100;
        gen_msg(3'd0, 4'd4, 4'd7, 32'h4000, -1);
        for (int i = 0; i < 20 && eq.size() > 2; i++) tick();
        chk("mid_burst_busy", busy, 1'b1);
        do_reset();
        gen_msg(3'd4, 4'd3, 4'd9, 32'h5000, -1);
        drain(50);

        // Randomized traffic with varying backpressure
        for (int r = 0; r < 6; r++) begin
            ready_prob = (r == 0) ? 100 : $urandom_range(100, 20);
            for (int i = 0; i < 40; i++) begin
                gen_msg(($urandom_range(9) == 0) ? 3'($urandom_range(7, 6)) : 3'($urandom_range(5)),
                        ($urandom_range(9) == 0) ? 4'($urandom_range(15, 7)) : 4'($urandom_range(6)),
                        4'($urandom), 32'($urandom), -1);
            end
            drain(3000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
